// File: rtl/adc_seq.sv
// adc_seq: round-robin sequencer sharing one ADC among several requesters; returns channel-tagged codes.
// Build macro ADC_SEQ_AVG_EN: four conversions per grant, result is their truncated average.
module adc_seq #(
    parameter int channels     = 4,
    parameter int bits         = 8,
    parameter int conv_latency = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [channels-1:0]         req,
    output logic [channels-1:0]         grant,
    output logic [$clog2(channels)-1:0] sel,
    output logic                        adc_clk,
    input  logic [bits-1:0]             adc_data,
    output logic [bits-1:0]             result,
    output logic                        done,
    output logic [$clog2(channels)-1:0] done_ch,
    output logic                        busy
);
    localparam int SEL_W = $clog2(channels);
    localparam int CNT_W = $clog2(conv_latency + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(conv_latency);

    typedef enum logic [1:0] {IDLE, SETTLE, CONV, WAIT} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [channels-1:0] r_req_smp;
    logic [SEL_W-1:0]    r_ptr;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_done_ch;
    logic [channels-1:0] r_grant;
    logic                r_adc_clk;
    logic                r_busy;
    logic                r_done;
    logic [bits-1:0]     r_result;
    logic [CNT_W-1:0]    r_cnt;

    logic [SEL_W:0]      w_cand;
    logic [SEL_W-1:0]    w_win;
    logic [SEL_W-1:0]    w_ptr_inc;
    logic                w_any;
    logic                w_accept;
    logic                w_expire;
    logic                w_last;
    logic [channels-1:0] w_grant_next;
    logic                w_busy_next;
    logic                w_adc_clk_next;
    logic                w_done_next;
    logic [bits-1:0]     w_result_next;
    logic [bits-1:0]     w_code;

    // Scan downward from the pointer's farthest neighbour so the nearest requester is kept last.
    always_comb begin
        w_cand = '0;
        w_win  = '0;
        for (int i = channels - 1; i >= 0; i--) begin
            w_cand = {1'b0, r_ptr} + (SEL_W+1)'(i);
            if (w_cand >= (SEL_W+1)'(channels)) begin
                w_cand = w_cand - (SEL_W+1)'(channels);
            end
            if (r_req_smp[w_cand[SEL_W-1:0]]) begin
                w_win = w_cand[SEL_W-1:0];
            end
        end
    end

    assign w_any     = |r_req_smp;
    assign w_accept  = (r_state == IDLE) && w_any;
    assign w_ptr_inc = (w_win == SEL_W'(channels - 1)) ? '0 : w_win + SEL_W'(1);
    assign w_expire  = (r_state == WAIT) && (r_cnt == CNT_W'(1));

`ifdef ADC_SEQ_AVG_EN
    logic [bits+1:0] r_acc;
    logic [1:0]      r_nconv;
    logic [bits+1:0] w_acc_sum;

    assign w_acc_sum = r_acc + {2'b00, adc_data};
    assign w_last    = (r_nconv == 2'd3);
    assign w_code    = w_acc_sum[bits+1:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_nconv <= '0;
        end else if (w_accept) begin
            r_acc   <= '0;
            r_nconv <= '0;
        end else if (w_expire) begin
            r_acc   <= w_acc_sum;
            r_nconv <= r_nconv + 2'd1;
        end
    end
`else
    assign w_last = 1'b1;
    assign w_code = adc_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_next = SETTLE;
            SETTLE:  w_state_next = CONV;
            CONV:    w_state_next = WAIT;
            WAIT:    if (w_expire) w_state_next = w_last ? IDLE : CONV;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so adc_clk is a clean flop output.
    always_comb begin
        w_grant_next   = '0;
        w_busy_next    = (w_state_next != IDLE);
        w_adc_clk_next = (w_state_next == CONV);
        w_done_next    = w_expire && w_last;
        w_result_next  = r_result;
        if (w_accept) begin
            w_grant_next[w_win] = 1'b1;
        end
        if (w_done_next) begin
            w_result_next = w_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_smp <= '0;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_done_ch <= '0;
            r_grant   <= '0;
            r_adc_clk <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_cnt     <= '0;
        end else begin
            r_req_smp <= (r_state == IDLE) ? req : '0;
            r_grant   <= w_grant_next;
            r_adc_clk <= w_adc_clk_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_result  <= w_result_next;
            if (w_accept) begin
                r_sel <= w_win;
                r_ptr <= w_ptr_inc;
            end
            if (r_state == CONV) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_done_next) begin
                r_done_ch <= r_sel;
            end
        end
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign adc_clk = r_adc_clk;
    assign result  = r_result;
    assign done    = r_done;
    assign done_ch = r_done_ch;
    assign busy    = r_busy;
endmodule

// File: tb/tb_adc_seq.sv
// Randomized bench for adc_seq against a transaction-level schedule model built from the timing rules.
// Honours ADC_SEQ_AVG_EN to expect four averaged conversions per grant.
module tb_adc_seq;
    localparam int CH   = 4;
    localparam int BITS = 8;
    localparam int LAT  = 2;
`ifdef ADC_SEQ_AVG_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   req;
    logic [CH-1:0]   grant;
    logic [1:0]      sel;
    logic            adc_clk;
    logic [BITS-1:0] adc_data;
    logic [BITS-1:0] result;
    logic            done;
    logic [1:0]      done_ch;
    logic            busy;

    adc_seq #(.channels(CH), .bits(BITS), .conv_latency(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .grant    (grant),
        .sel      (sel),
        .adc_clk  (adc_clk),
        .adc_data (adc_data),
        .result   (result),
        .done     (done),
        .done_ch  (done_ch),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n;          // index of the clock edge being processed
    // Schedule model: edge of the accepted request, its winner, the done edge, first idle sampling edge.
    int m_g, m_win, m_done, m_idle, m_ptr, m_sel, m_result, m_donech, m_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int rr_pick(input logic [CH-1:0] r, input int ptr);
        for (int i = 0; i < CH; i++) begin
            if (r[(ptr + i) % CH]) return (ptr + i) % CH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_g = -1000; m_done = -1000; m_idle = 0; m_win = 0;
        m_ptr = 0; m_sel = 0; m_result = 0; m_donech = 0; m_acc = 0;
    endtask

    task automatic model_edge(input logic [CH-1:0] rq, input logic [BITS-1:0] d);
        int k;
        k = n - (m_g + 2);
        if (m_g >= 0 && k > 0 && k % (LAT + 1) == 0 && k / (LAT + 1) <= NCONV) m_acc += int'(d);
        if (n == m_done) begin
            m_result = m_acc / NCONV;
            m_donech = m_win;
            $display("txn: ch=%0d result=%02h done_edge=%0d", m_donech, m_result, n);
        end
        if (n >= m_idle && rq != '0) begin
            m_win  = rr_pick(rq, m_ptr);
            m_ptr  = (m_win + 1) % CH;
            m_g    = n;
            m_acc  = 0;
            m_done = n + 2 + NCONV * (LAT + 1);
            m_idle = m_done + 1;
        end
        if (n == m_g + 1) m_sel = m_win;
    endtask

    task automatic compare_outputs();
        int k;
        logic [CH-1:0] exp_grant;
        exp_grant = '0;
        if (n == m_g + 1) exp_grant[m_win] = 1'b1;
        k = n - (m_g + 2);
        check("grant",   32'(grant),   32'(exp_grant));
        check("busy",    32'(busy),    32'(n >= m_g + 1 && n < m_done));
        check("adc_clk", 32'(adc_clk), 32'(m_g >= 0 && k >= 0 && k % (LAT + 1) == 0 && k / (LAT + 1) < NCONV));
        check("done",    32'(done),    32'(n == m_done));
        check("result",  32'(result),  32'(m_result));
        check("done_ch", 32'(done_ch), 32'(m_donech));
        check("sel",     32'(sel),     32'(m_sel));
    endtask

    task automatic check_all_zero(input string phase);
        check({phase, "_grant"},   32'(grant),   32'(0));
        check({phase, "_sel"},     32'(sel),     32'(0));
        check({phase, "_adc_clk"}, 32'(adc_clk), 32'(0));
        check({phase, "_result"},  32'(result),  32'(0));
        check({phase, "_done"},    32'(done),    32'(0));
        check({phase, "_done_ch"}, 32'(done_ch), 32'(0));
        check({phase, "_busy"},    32'(busy),    32'(0));
    endtask

    task automatic step(input logic [CH-1:0] rq, input logic [BITS-1:0] d);
        req      = rq;
        adc_data = d;
        @(posedge clk);
        model_edge(rq, d);
        #1;
        compare_outputs();
        n++;
        @(negedge clk);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [CH-1:0] rq_r;
        rst = 1'b1; req = '0; adc_data = '0; n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single request on channel 2 with a fixed code.
        step(4'b0100, 8'hA5);
        repeat (8) step(4'b0000, 8'hA5);

`ifdef ADC_SEQ_AVG_EN
        // Successive captures see 10,11,12,13.
        for (int j = 0; j < 18; j++) begin
            step((j == 0) ? 4'b0001 : 4'b0000, 8'h10 + ((j >= 5) ? 8'((j - 5) / 3) : 8'h00));
        end
`endif

        // All channels held: strict rotation at full throughput.
        repeat (6 * NCONV * 6) step(4'b1111, 8'($urandom));
        repeat (20) step(4'b0000, 8'($urandom));

        // Channel 3 granted, then 1001 held.
        step(4'b1000, 8'($urandom));
        repeat (12) step(4'b0000, 8'($urandom));
        repeat (30) step(4'b1001, 8'($urandom));
        repeat (20) step(4'b0000, 8'($urandom));

        // Request dropped right after it is seen.
        step(4'b0010, 8'h5C);
        repeat (20) step(4'b0000, 8'($urandom));

        // Reset in the middle of WAIT, then 1010 must grant channel 1.
        step(4'b0100, 8'h3C);
        repeat (3) step(4'b0000, 8'h3C);
        async_reset();
        step(4'b1010, 8'h77);
        repeat (20 * NCONV) step(4'b0000, 8'($urandom));

        rq_r = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rq_r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) async_reset();
            step(rq_r, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/adc_seq.md
# adc_seq

Round-robin conversion sequencer that shares one `adc` instance among several analog requesters. It arbitrates channel requests, drives the analog mux select, and issues a single-cycle conversion clock to the ADC. It waits a fixed conversion latency, then captures the ADC code and returns it tagged with its channel. It sits between the channel clients and the shared converter.

## Interface
- `channels`, 4, number of requesters; ≥2.
- `bits`, 8, ADC resolution; must match the ADC `bits`.
- `conv_latency`, 2, cycles from the end of the `adc_clk` pulse to a valid `adc_data`; ≥1; must cover ADC `td`.
- `clk` input 1: single clock; all logic is on its posedge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input `channels`: level request per channel.
- `grant` output `channels`: one-hot, high for exactly one cycle when a request is accepted.
- `sel` output `$clog2(channels)`: analog mux select for the granted channel.
- `adc_clk` output 1: registered conversion strobe to ADC `clk`.
- `adc_data` input `bits`: ADC output code; bit `bits-1` is the MSB.
- `result` output `bits`: captured (or averaged) code.
- `done` output 1: one-cycle pulse; `result`/`done_ch` are valid while it is high.
- `done_ch` output `$clog2(channels)`: channel that produced `result`.
- `busy` output 1: high from grant until done.

## Operation
- States: IDLE, SETTLE, CONV, WAIT.
- IDLE:
  - If any `req` is high, pick the winner round-robin, load `sel`, and go to SETTLE.
  - If no `req` is high, stay in IDLE.
- SETTLE (1 cycle):
  - `grant[sel]`=1 and `busy`=1.
  - Allows mux settling. Go to CONV.
- CONV (1 cycle): `adc_clk`=1. Load the wait counter with `conv_latency`. Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter expires, register `adc_data` into `result` and set `done`=1, `done_ch`=`sel`. Return to IDLE.
- Round-robin arbitration:
  - After reset, the priority pointer is at channel 0.
  - After granting channel k, the pointer moves to (k+1) mod `channels`.
  - Among the high `req` bits, the first one found at or after the pointer wins.
- `req` is sampled only in IDLE. Dropping `req` after grant does not abort the conversion, and `done` still fires.
- `sel` is held constant from SETTLE until the next grant.
- Reset values: `grant`=0, `sel`=0, `adc_clk`=0, `result`=0, `done`=0, `done_ch`=0, `busy`=0, state IDLE, pointer 0.
- Reset mid-operation:
  - The conversion in flight is discarded and no `done` is produced.
  - All outputs return to their reset values immediately (asynchronous).

## Timing
- `req` is seen high in IDLE at edge E.
  - `grant` and `busy` rise after E+1.
  - `adc_clk` is high for the cycle after E+2.
  - WAIT runs from E+3 for `conv_latency` cycles.
  - `result`, `done`, and `done_ch` update at edge E+3+`conv_latency`, and `busy` falls at that same edge.
- The earliest next grant is after edge E+4+`conv_latency`. Throughput is one conversion per `conv_latency`+4 cycles.
- `adc_clk` is glitch-free: a registered output, high for exactly one `clk` cycle per conversion.

## Configuration
- Macro `ADC_SEQ_AVG_EN`.
- Defined:
  - Each grant performs 4 conversions.
  - After each WAIT expiry, `adc_data` is added to a (`bits`+2)-bit accumulator.
  - The first 3 expiries return to CONV; SETTLE is not repeated.
  - After the 4th expiry, `result` = accumulator >> 2 (truncating), and `done` fires at edge E+2+4(`conv_latency`+1).
  - The accumulator clears on grant and on reset.
- Undefined: single conversion per grant, no accumulator.

## Test plan
- Single request, `conv_latency`=2, `req`=4'b0100, `adc_data`=8'hA5:
  - `grant`=4'b0100 after E+1, `sel`=2.
  - One `adc_clk` pulse after E+2.
  - `done` at E+5 with `result`=8'hA5, `done_ch`=2.
- `req`=4'b1111 held: grants occur in order 0, 1, 2, 3, 0, each `done_ch` matches its grant, and the spacing is 6 cycles.
- Fairness: after channel 3 is granted, with `req`=4'b1001 held, the next grant is channel 0.
- Request withdrawn after grant: `req[1]` drops in SETTLE and the conversion still completes with `done_ch`=1.
- Reset mid-WAIT: all outputs go to 0 and no `done` is produced. Afterwards, `req`=4'b1010 grants channel 1 first (pointer reset).
- With `ADC_SEQ_AVG_EN`, `adc_data` = 8'h10, 8'h11, 8'h12, 8'h13 on successive captures: exactly 4 `adc_clk` pulses, and `result`=8'h11 at E+14.
